// File: rtl/mc_controller_pkg.sv
// -----------------------------------------------------------------------------
// mc_controller_pkg
//
// Shared constants for the multicycle MIPS-subset control unit:
//   - FSM state codes (4-bit, debug-visible on the controller's state port)
//   - opcode and funct field values the controller recognises
//   - ALU function codes driven to the ALU (bit3 = invert B + carry-in)
//   - aluop encodings passed from the FSM to the ALU decoder
// -----------------------------------------------------------------------------
package mc_controller_pkg;

   localparam int ST_W = 4;

   // FSM state encodings. Codes 12..15 are unused and recover to FETCH.
   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_RTYPEEX = 4'd6;
   localparam logic [3:0] S_RTYPEWB = 4'd7;
   localparam logic [3:0] S_BEQEX   = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JEX     = 4'd11;

   // Opcodes (instr[31:26]).
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct codes (instr[5:0]).
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU function codes.
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b1010;
   localparam logic [3:0] ALU_SLT = 4'b1011;

   // aluop encodings from the FSM to the ALU decoder.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B-input select codes.
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // Next-PC select codes.
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage : mc_controller_pkg

// File: rtl/mc_controller_aludec.sv
// -----------------------------------------------------------------------------
// mc_aludec
//
// Combinational ALU decoder. Turns the FSM's aluop request and the R-type
// funct field into the 4-bit ALU function code.
//
// Ports:
//   aluop_i        [1:0] 00 add, 01 sub, 10 use funct
//   funct_i        [5:0] instr[5:0]
//   alucontrol_o   [3:0] ALU function select
//   funct_legal_o        1 when funct_i is one of the supported R-type ops
// -----------------------------------------------------------------------------
module mc_aludec
   import mc_controller_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [5:0] funct_i,
   output logic [3:0] alucontrol_o,
   output logic       funct_legal_o
);

   logic [3:0] funct_code;

   // funct_legal_o depends only on funct so the FSM can use it in the
   // writeback state, where aluop has already returned to add.
   always_comb begin
      funct_code    = ALU_ADD;
      funct_legal_o = 1'b1;
      case (funct_i)
         FN_ADD:  funct_code = ALU_ADD;
         FN_SUB:  funct_code = ALU_SUB;
         FN_AND:  funct_code = ALU_AND;
         FN_OR:   funct_code = ALU_OR;
         FN_SLT:  funct_code = ALU_SLT;
         default: begin
            funct_code    = ALU_ADD;
            funct_legal_o = 1'b0;
         end
      endcase
   end

   always_comb begin
      alucontrol_o = ALU_ADD;
      case (aluop_i)
         ALUOP_ADD:   alucontrol_o = ALU_ADD;
         ALUOP_SUB:   alucontrol_o = ALU_SUB;
         ALUOP_FUNCT: alucontrol_o = funct_code;
         default:     alucontrol_o = ALU_ADD;
      endcase
   end

endmodule : mc_aludec

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
//
// Multicycle control unit for a 32-bit MIPS-subset datapath. A Moore FSM
// steps each instruction through fetch/decode/execute/memory/writeback and
// decodes the datapath enables, mux selects and ALU function from the state.
//
// Ports:
//   clk         system clock, all state on rising edge
//   reset_n     asynchronous active-low reset
//   op          instr[31:26]
//   funct       instr[5:0]
//   zero        ALU zero flag (same-cycle combinational)
//   pcen        PC write enable
//   irwrite     instruction register write enable
//   memwrite    data memory write strobe
//   regwrite    register file write enable
//   iord        memory address select (0 PC, 1 ALUOut)
//   memtoreg    writeback select (0 ALUOut, 1 memory data)
//   regdst      destination register select (0 rt, 1 rd)
//   alusrca     ALU A select (0 PC, 1 register A)
//   alusrcb     ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   pcsrc       next-PC select (00 ALU, 01 ALUOut, 10 jump)
//   alucontrol  ALU function code
//   state       current FSM state (debug)
// -----------------------------------------------------------------------------
module mc_controller
   import mc_controller_pkg::*;
#(
   parameter int STATE_W = ST_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   output logic               pcen,
   output logic               irwrite,
   output logic               memwrite,
   output logic               regwrite,
   output logic               iord,
   output logic               memtoreg,
   output logic               regdst,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [3:0]         alucontrol,
   output logic [STATE_W-1:0] state
);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;

   // Raw state decode, before the reset gating of the write enables.
   logic       pcwrite;
   logic       branch;
   logic       irwrite_raw;
   logic       memwrite_raw;
   logic       regwrite_raw;
   logic [1:0] aluop;
   logic       funct_legal;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW:   state_d = S_MEMADR;
               OP_RTYPE:       state_d = S_RTYPEEX;
               OP_BEQ, OP_BNE: state_d = S_BEQEX;
               OP_ADDI:        state_d = S_ADDIEX;
               OP_J:           state_d = S_JEX;
               // Unsupported opcodes retire as a NOP straight from decode.
               default:        state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_d = S_MEMWB;
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_MEMWB, S_MEMWR, S_RTYPEWB, S_ADDIWB, S_BEQEX, S_JEX:
                    state_d = S_FETCH;
         // Codes 12..15 are unreachable in normal operation; recover.
         default:   state_d = S_FETCH;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Moore output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      pcwrite      = 1'b0;
      branch       = 1'b0;
      irwrite_raw  = 1'b0;
      memwrite_raw = 1'b0;
      regwrite_raw = 1'b0;
      iord         = 1'b0;
      memtoreg     = 1'b0;
      regdst       = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = SRCB_REG;
      pcsrc        = PCSRC_ALU;
      aluop        = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            irwrite_raw = 1'b1;
            pcwrite     = 1'b1;
            alusrcb     = SRCB_FOUR;
            aluop       = ALUOP_ADD;
         end
         S_DECODE: begin
            // Precompute the branch target into ALUOut.
            alusrcb = SRCB_IMMSH;
            aluop   = ALUOP_ADD;
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            aluop   = ALUOP_ADD;
         end
         S_MEMRD: begin
            iord = 1'b1;
         end
         S_MEMWB: begin
            regwrite_raw = 1'b1;
            memtoreg     = 1'b1;
         end
         S_MEMWR: begin
            iord         = 1'b1;
            memwrite_raw = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            regdst       = 1'b1;
            // An unsupported funct retires without touching the register file.
            regwrite_raw = funct_legal;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = PCSRC_ALUOUT;
            branch  = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            aluop   = ALUOP_ADD;
         end
         S_ADDIWB: begin
            regwrite_raw = 1'b1;
         end
         S_JEX: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
         end
         default: begin
            // Illegal codes drive the all-zero defaults.
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // ALU decoder
   // ---------------------------------------------------------------------------
   mc_aludec u_aludec (
      .aluop_i       (aluop),
      .funct_i       (funct),
      .alucontrol_o  (alucontrol),
      .funct_legal_o (funct_legal)
   );

   // ---------------------------------------------------------------------------
   // Write enables
   // ---------------------------------------------------------------------------
   // op[0] distinguishes bne (1) from beq (0): bne takes the branch when the
   // subtraction is non-zero. The reset term keeps every write strobe low for
   // the whole time reset_n is asserted, including the instant it falls.
   assign pcen     = reset_n & (pcwrite | (branch & (zero ^ op[0])));
   assign irwrite  = reset_n & irwrite_raw;
   assign memwrite = reset_n & memwrite_raw;
   assign regwrite = reset_n & regwrite_raw;

   assign state = state_q;

endmodule : mc_controller

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
//
// Bench for mc_controller. The driver issues instructions one cycle at a time
// and, for every cycle, pushes the expected output vector (computed from a
// per-instruction step model) onto exp_q. A monitor on the falling edge pops
// and compares whenever an expectation is pending. Reset and asynchronous
// abort behaviour are checked directly by the driver.
// -----------------------------------------------------------------------------
module tb_mc_controller;

   localparam int W = 20;

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] RTY  = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] BNE  = 6'b000101;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] JMP  = 6'b000010;

   // Expected vector while reset is held: state 0, no write strobes, FETCH muxes.
   localparam logic [W-1:0] RESET_VEC = {4'd0, 8'b0000_0000, 2'b01, 2'b00, 4'b0010};

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [3:0] alucontrol;
   logic [3:0] state;

   always #5 clk = ~clk;

   mc_controller #(.STATE_W(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pcen       (pcen),
      .irwrite    (irwrite),
      .memwrite   (memwrite),
      .regwrite   (regwrite),
      .iord       (iord),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol),
      .state      (state)
   );

   logic [W-1:0] dut_vec;
   assign dut_vec = {state, pcen, irwrite, memwrite, regwrite, iord, memtoreg,
                     regdst, alusrca, alusrcb, pcsrc, alucontrol};

   // ---------------------------------------------------------------------------
   // Reference model: instruction-level view of the expected outputs
   // ---------------------------------------------------------------------------
   int errors = 0;
   int checks = 0;

   // Cycles an instruction takes, FETCH included.
   function automatic int instr_len(input logic [5:0] o);
      case (o)
         LW:                 return 5;
         SW, RTY, ADDI:      return 4;
         BEQ, BNE, JMP:      return 3;
         default:            return 2;
      endcase
   endfunction

   // ALU code for an R-type funct; legal=0 for unsupported functs.
   function automatic logic [4:0] rtype_alu(input logic [5:0] f);
      case (f)
         6'b100000: return {1'b1, 4'b0010};
         6'b100010: return {1'b1, 4'b1010};
         6'b100100: return {1'b1, 4'b0000};
         6'b100101: return {1'b1, 4'b0001};
         6'b101010: return {1'b1, 4'b1011};
         default:   return {1'b0, 4'b0010};
      endcase
   endfunction

   // Expected outputs for step 'step' (0 = fetch) of instruction (o, f).
   function automatic logic [W-1:0] exp_vec(input logic [5:0] o, input logic [5:0] f,
                                            input logic z, input int step);
      logic [3:0] st;
      logic       e_pcen, e_irw, e_mw, e_rw, e_iord, e_m2r, e_rdst, e_asa;
      logic [1:0] e_asb, e_pcs;
      logic [3:0] e_alc;
      logic [4:0] ra;
      st = 4'd0; e_pcen = 0; e_irw = 0; e_mw = 0; e_rw = 0; e_iord = 0;
      e_m2r = 0; e_rdst = 0; e_asa = 0; e_asb = 2'b00; e_pcs = 2'b00; e_alc = 4'b0010;
      ra = rtype_alu(f);
      if (step == 0) begin
         st = 4'd0; e_irw = 1; e_pcen = 1; e_asb = 2'b01;
      end else if (step == 1) begin
         st = 4'd1; e_asb = 2'b11;
      end else begin
         case (o)
            LW, SW: begin
               if (step == 2) begin
                  st = 4'd2; e_asa = 1; e_asb = 2'b10;
               end else if (o == SW) begin
                  st = 4'd5; e_iord = 1; e_mw = 1;
               end else if (step == 3) begin
                  st = 4'd3; e_iord = 1;
               end else begin
                  st = 4'd4; e_rw = 1; e_m2r = 1;
               end
            end
            RTY: begin
               if (step == 2) begin
                  st = 4'd6; e_asa = 1; e_alc = ra[3:0];
               end else begin
                  st = 4'd7; e_rdst = 1; e_rw = ra[4];
               end
            end
            BEQ, BNE: begin
               st = 4'd8; e_asa = 1; e_alc = 4'b1010; e_pcs = 2'b01;
               e_pcen = (o == BNE) ? ~z : z;
            end
            ADDI: begin
               if (step == 2) begin
                  st = 4'd9; e_asa = 1; e_asb = 2'b10;
               end else begin
                  st = 4'd10; e_rw = 1;
               end
            end
            JMP: begin
               st = 4'd11; e_pcs = 2'b10; e_pcen = 1;
            end
            default: st = 4'd0;
         endcase
      end
      return {st, e_pcen, e_irw, e_mw, e_rw, e_iord, e_m2r, e_rdst, e_asa,
              e_asb, e_pcs, e_alc};
   endfunction

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [W-1:0] exp_q[$];
   string        tag_q[$];

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         string        t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         checks++;
         if (dut_vec !== e) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h (t=%0t)", t, dut_vec, e, $time);
         end
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %05h expected %05h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver. Called just after a rising edge with the DUT in FETCH; returns
   // just after a rising edge. zf < 0 randomises zero each cycle. nsteps = 0
   // runs the whole instruction, otherwise stops after nsteps cycles.
   // ---------------------------------------------------------------------------
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zf,
                            input int nsteps, input string name);
      int n;
      n = instr_len(o);
      if (nsteps > 0 && nsteps < n) n = nsteps;
      op    = o;
      funct = f;
      for (int s = 0; s < n; s++) begin
         zero = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
         exp_q.push_back(exp_vec(o, f, zero, s));
         tag_q.push_back($sformatf("%s step%0d", name, s));
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [5:0] rop, rfn;
      logic [5:0] op_tab[7];
      logic [5:0] fn_tab[5];
      op_tab = '{LW, SW, RTY, BEQ, BNE, ADDI, JMP};
      fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

      reset_n = 1'b0;
      op      = LW;
      funct   = 6'b000000;
      zero    = 1'b0;

      // Reset held for three cycles with a lw opcode present.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("reset hold %0d", i), dut_vec, RESET_VEC);
      end
      reset_n = 1'b1;

      // Directed instructions.
      run_instr(LW,   6'b000000, -1, 0, "lw");
      run_instr(RTY,  6'b100010, -1, 0, "rtype sub");
      run_instr(RTY,  6'b111111, -1, 0, "rtype bad funct");
      run_instr(BEQ,  6'b000000,  1, 0, "beq taken");
      run_instr(BEQ,  6'b000000,  0, 0, "beq not taken");
      run_instr(BNE,  6'b000000,  0, 0, "bne taken");
      run_instr(BNE,  6'b000000,  1, 0, "bne not taken");
      run_instr(JMP,  6'b000000, -1, 0, "j");
      run_instr(6'b111111, 6'b000000, -1, 0, "illegal op");
      run_instr(SW,   6'b000000, -1, 0, "sw");
      run_instr(ADDI, 6'b000000, -1, 0, "addi");
      run_instr(RTY,  6'b101010, -1, 0, "rtype slt");

      // Mid-sw abort: reset falls asynchronously while memwrite is high.
      run_instr(SW, 6'b000000, -1, 3, "sw pre-abort");
      check("abort memwr state", dut_vec, exp_vec(SW, 6'b000000, zero, 3));
      #2;
      reset_n = 1'b0;
      #1;
      check("abort async reset", dut_vec, RESET_VEC);
      @(posedge clk);
      #1;
      check("abort reset held", dut_vec, RESET_VEC);
      reset_n = 1'b1;

      // Randomised instruction stream.
      for (int i = 0; i < 200; i++) begin
         int k;
         k = $urandom_range(0, 8);
         rop = (k < 7) ? op_tab[k] : 6'($urandom_range(0, 63));
         rfn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                          : fn_tab[$urandom_range(0, 4)];
         run_instr(rop, rfn, -1, 0, $sformatf("rand%0d op%06b fn%06b", i, rop, rfn));
      end

      // Let the monitor drain, then confirm nothing was left unchecked.
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: %0d left, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog in case the stimulus ever stalls.
   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule : tb_mc_controller
